// File: rtl/ticket_dispense_if.sv
// ticket_dispense_if: sale handshake between the fare datapath, the
// ticket dispense controller and the printer / coin hopper.
// The master side is the controller. The slave side is the environment:
// the fare datapath plus both dispensers.
interface ticket_dispense_if #(
   parameter int CHANGE_W = 7
) ();
   logic                start;
   logic [2:0]          ticket_count;
   logic [CHANGE_W-1:0] change_amt;
   logic                tkt_req;
   logic                tkt_ack;
   logic                coin_req;
   logic [1:0]          coin_sel;
   logic                coin_ack;
   logic                busy;
   logic                done;
   logic                error;
   logic [2:0]          tickets_issued;
   logic [CHANGE_W-1:0] change_left;

   modport master (
      input  start, ticket_count, change_amt, tkt_ack, coin_ack,
      output tkt_req, coin_req, coin_sel, busy, done, error,
             tickets_issued, change_left
   );

   modport slave (
      output start, ticket_count, change_amt, tkt_ack, coin_ack,
      input  tkt_req, coin_req, coin_sel, busy, done, error,
             tickets_issued, change_left
   );
endinterface

// File: rtl/ticket_dispense_controller.sv
// ticket_dispense_controller: after a completed purchase, issues the tickets
// one at a time, then pays the change greedily in $50/$10/$5 coins.
// Optional feature macro HOPPER_TIMEOUT_EN adds an 8-bit stall watchdog.
// When the macro is not defined, the block waits for each ack indefinitely.
module ticket_dispense_controller #(
   parameter int MAX_TICKETS = 5,
   parameter int CHANGE_W    = 7
) (
   input  logic              clk,
   input  logic              reset,
   ticket_dispense_if.master bus
);
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      TKT  = 3'd1,
      COIN = 3'd2,
      DONE = 3'd3,
      ERR  = 3'd4
   } state_t;

   localparam logic [2:0]          MAX_T  = 3'(MAX_TICKETS);
   localparam logic [CHANGE_W-1:0] ZERO_C = {CHANGE_W{1'b0}};
   localparam logic [CHANGE_W-1:0] FIVE_C = CHANGE_W'(5);

   // Greedy denomination choice for the amount still owed.
   function automatic logic [1:0] greedy_sel(input logic [CHANGE_W-1:0] amt);
      if (amt >= CHANGE_W'(50)) begin
         greedy_sel = 2'b11;
      end else if (amt >= CHANGE_W'(10)) begin
         greedy_sel = 2'b10;
      end else begin
         greedy_sel = 2'b01;
      end
   endfunction

   // Dollar value of a coin code.
   function automatic logic [CHANGE_W-1:0] coin_value(input logic [1:0] sel);
      case (sel)
         2'b11:   coin_value = CHANGE_W'(50);
         2'b10:   coin_value = CHANGE_W'(10);
         2'b01:   coin_value = CHANGE_W'(5);
         default: coin_value = ZERO_C;
      endcase
   endfunction

   state_t              state_r, state_nx_s;
   logic [2:0]          cnt_r, cnt_nx_s;
   logic [2:0]          issued_r, issued_nx_s, issued_inc_s;
   logic [CHANGE_W-1:0] change_r, change_nx_s, change_sub_s;
   logic                tkt_req_r, coin_req_r, busy_r, done_r, error_r;
   logic                error_nx_s;
   logic [1:0]          coin_sel_s;
   logic                legal_s;
`ifdef HOPPER_TIMEOUT_EN
   logic [7:0]          wd_r, wd_nx_s;
   logic                stall_s;
`endif

   assign legal_s = (bus.ticket_count != 3'd0) && (bus.ticket_count <= MAX_T) &&
                    ((bus.change_amt % FIVE_C) == ZERO_C);

   // Coin code follows the registered remainder; zero whenever no coin is requested.
   always_comb begin
      coin_sel_s = 2'b00;
      if (state_r == COIN) begin
         coin_sel_s = greedy_sel(change_r);
      end else begin
         coin_sel_s = 2'b00;
      end
   end

   // Next-state and next-register values for the sale sequencer.
   always_comb begin
      state_nx_s   = state_r;
      cnt_nx_s     = cnt_r;
      issued_nx_s  = issued_r;
      change_nx_s  = change_r;
      error_nx_s   = error_r;
      issued_inc_s = issued_r + 3'd1;
      change_sub_s = change_r - coin_value(coin_sel_s);
`ifdef HOPPER_TIMEOUT_EN
      wd_nx_s      = 8'd0;
      stall_s      = ((state_r == TKT) && !bus.tkt_ack) ||
                     ((state_r == COIN) && !bus.coin_ack);
`endif
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               if (legal_s) begin
                  cnt_nx_s    = bus.ticket_count;
                  issued_nx_s = 3'd0;
                  change_nx_s = bus.change_amt;
                  error_nx_s  = 1'b0;
                  state_nx_s  = TKT;
               end else begin
                  state_nx_s  = ERR;
               end
            end else begin
               state_nx_s = IDLE;
            end
         end
         TKT: begin
            if (bus.tkt_ack) begin
               issued_nx_s = issued_inc_s;
               if (issued_inc_s == cnt_r) begin
                  // Go straight to the hopper so coin_req follows with no bubble.
                  if (change_r != ZERO_C) begin
                     state_nx_s = COIN;
                  end else begin
                     state_nx_s = DONE;
                  end
               end else begin
                  state_nx_s = TKT;
               end
            end else begin
               state_nx_s = TKT;
            end
         end
         COIN: begin
            if (bus.coin_ack) begin
               change_nx_s = change_sub_s;
               if (change_sub_s == ZERO_C) begin
                  state_nx_s = DONE;
               end else begin
                  state_nx_s = COIN;
               end
            end else begin
               state_nx_s = COIN;
            end
         end
         DONE: begin
            state_nx_s = IDLE;
         end
         ERR: begin
            error_nx_s = 1'b1;
            state_nx_s = IDLE;
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
`ifdef HOPPER_TIMEOUT_EN
      // A stuck dispenser aborts the sale but keeps the counters for service readout.
      if (stall_s) begin
         if (wd_r == 8'd254) begin
            state_nx_s = IDLE;
            error_nx_s = 1'b1;
            wd_nx_s    = 8'd255;
         end else begin
            wd_nx_s    = wd_r + 8'd1;
         end
      end else begin
         wd_nx_s = 8'd0;
      end
`endif
   end

   // State and registered outputs; the outputs follow the next state directly.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r    <= IDLE;
         cnt_r      <= 3'd0;
         issued_r   <= 3'd0;
         change_r   <= ZERO_C;
         tkt_req_r  <= 1'b0;
         coin_req_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         error_r    <= 1'b0;
`ifdef HOPPER_TIMEOUT_EN
         wd_r       <= 8'd0;
`endif
      end else begin
         state_r    <= state_nx_s;
         cnt_r      <= cnt_nx_s;
         issued_r   <= issued_nx_s;
         change_r   <= change_nx_s;
         tkt_req_r  <= (state_nx_s == TKT);
         coin_req_r <= (state_nx_s == COIN);
         busy_r     <= (state_nx_s == TKT) || (state_nx_s == COIN);
         done_r     <= (state_nx_s == DONE);
         error_r    <= error_nx_s;
`ifdef HOPPER_TIMEOUT_EN
         wd_r       <= wd_nx_s;
`endif
      end
   end

   assign bus.tkt_req        = tkt_req_r;
   assign bus.coin_req       = coin_req_r;
   assign bus.coin_sel       = coin_sel_s;
   assign bus.busy           = busy_r;
   assign bus.done           = done_r;
   assign bus.error          = error_r;
   assign bus.tickets_issued = issued_r;
   assign bus.change_left    = change_r;
endmodule

// File: tb/tb_ticket_dispense_controller.sv
// tb_ticket_dispense_controller: directed sale scenarios with hand-computed
// expectations for the default build (no hopper watchdog).
module tb_ticket_dispense_controller;
   localparam int CW = 7;

   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;
   int   high_cnt;
   int   done_cnt;

   ticket_dispense_if #(.CHANGE_W(CW)) bus ();

   ticket_dispense_controller #(.MAX_TICKETS(5), .CHANGE_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sale(input logic [2:0] tc, input logic [CW-1:0] ca);
      bus.start        = 1'b1;
      bus.ticket_count = tc;
      bus.change_amt   = ca;
      step();
      bus.start        = 1'b0;
   endtask

   initial begin
      reset            = 1'b0;
      bus.start        = 1'b0;
      bus.ticket_count = 3'd0;
      bus.change_amt   = 7'd0;
      bus.tkt_ack      = 1'b0;
      bus.coin_ack     = 1'b0;
      step();
      step();
      chk("rst_tkt_req",  32'(bus.tkt_req), 32'd0);
      chk("rst_coin_req", 32'(bus.coin_req), 32'd0);
      chk("rst_coin_sel", 32'(bus.coin_sel), 32'd0);
      chk("rst_busy",     32'(bus.busy), 32'd0);
      chk("rst_done",     32'(bus.done), 32'd0);
      chk("rst_error",    32'(bus.error), 32'd0);
      chk("rst_issued",   32'(bus.tickets_issued), 32'd0);
      chk("rst_change",   32'(bus.change_left), 32'd0);
      reset = 1'b1;
      step();

      // 5 tickets + one $5 coin, both acks high
      bus.tkt_ack  = 1'b1;
      bus.coin_ack = 1'b1;
      sale(3'd5, 7'd5);
      chk("t1_e0_busy",    32'(bus.busy), 32'd1);
      chk("t1_e0_tkt_req", 32'(bus.tkt_req), 32'd1);
      chk("t1_e0_change",  32'(bus.change_left), 32'd5);
      for (int i = 1; i <= 4; i++) begin
         step();
         chk("t1_issued", 32'(bus.tickets_issued), 32'(i));
         chk("t1_tkt_req", 32'(bus.tkt_req), 32'd1);
      end
      step();
      chk("t1_e5_issued",   32'(bus.tickets_issued), 32'd5);
      chk("t1_e5_tkt_req",  32'(bus.tkt_req), 32'd0);
      chk("t1_e5_coin_req", 32'(bus.coin_req), 32'd1);
      chk("t1_e5_coin_sel", 32'(bus.coin_sel), 32'd1);
      chk("t1_e5_done",     32'(bus.done), 32'd0);
      step();
      chk("t1_e6_done",     32'(bus.done), 32'd1);
      chk("t1_e6_change",   32'(bus.change_left), 32'd0);
      chk("t1_e6_busy",     32'(bus.busy), 32'd0);
      chk("t1_e6_coin_req", 32'(bus.coin_req), 32'd0);
      step();
      chk("t1_e7_done",     32'(bus.done), 32'd0);

      // 2 tickets, $65 change -> 50, 10, 5
      sale(3'd2, 7'd65);
      chk("t2_e0_change", 32'(bus.change_left), 32'd65);
      step();
      chk("t2_e1_issued", 32'(bus.tickets_issued), 32'd1);
      step();
      chk("t2_e2_coin_req", 32'(bus.coin_req), 32'd1);
      chk("t2_e2_sel",      32'(bus.coin_sel), 32'd3);
      chk("t2_e2_change",   32'(bus.change_left), 32'd65);
      step();
      chk("t2_e3_sel",      32'(bus.coin_sel), 32'd2);
      chk("t2_e3_change",   32'(bus.change_left), 32'd15);
      chk("t2_e3_done",     32'(bus.done), 32'd0);
      step();
      chk("t2_e4_sel",      32'(bus.coin_sel), 32'd1);
      chk("t2_e4_change",   32'(bus.change_left), 32'd5);
      chk("t2_e4_done",     32'(bus.done), 32'd0);
      step();
      chk("t2_e5_done",     32'(bus.done), 32'd1);
      chk("t2_e5_change",   32'(bus.change_left), 32'd0);
      chk("t2_e5_sel",      32'(bus.coin_sel), 32'd0);
      step();
      chk("t2_e6_done",     32'(bus.done), 32'd0);

      // 1 ticket, no change, printer stalls 4 cycles
      bus.tkt_ack = 1'b0;
      sale(3'd1, 7'd0);
      chk("t3_e0_tkt_req", 32'(bus.tkt_req), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         step();
         chk("t3_stall_tkt_req", 32'(bus.tkt_req), 32'd1);
         chk("t3_stall_issued",  32'(bus.tickets_issued), 32'd0);
      end
      bus.tkt_ack = 1'b1;
      step();
      chk("t3_done",     32'(bus.done), 32'd1);
      chk("t3_issued",   32'(bus.tickets_issued), 32'd1);
      chk("t3_tkt_req",  32'(bus.tkt_req), 32'd0);
      chk("t3_coin_req", 32'(bus.coin_req), 32'd0);
      step();
      chk("t3_done_end", 32'(bus.done), 32'd0);

      // Illegal starts: zero tickets, too many tickets, change not a multiple of 5
      sale(3'd0, 7'd0);
      chk("t4a_e0_busy",  32'(bus.busy), 32'd0);
      chk("t4a_e0_error", 32'(bus.error), 32'd0);
      step();
      chk("t4a_error",    32'(bus.error), 32'd1);
      chk("t4a_done",     32'(bus.done), 32'd0);
      chk("t4a_tkt_req",  32'(bus.tkt_req), 32'd0);
      sale(3'd6, 7'd0);
      chk("t4b_e0_busy",  32'(bus.busy), 32'd0);
      chk("t4b_e0_tkt",   32'(bus.tkt_req), 32'd0);
      step();
      chk("t4b_error",    32'(bus.error), 32'd1);
      chk("t4b_done",     32'(bus.done), 32'd0);
      sale(3'd2, 7'd7);
      chk("t4c_e0_busy",  32'(bus.busy), 32'd0);
      chk("t4c_e0_tkt",   32'(bus.tkt_req), 32'd0);
      step();
      chk("t4c_error",    32'(bus.error), 32'd1);
      chk("t4c_done",     32'(bus.done), 32'd0);
      chk("t4c_coin_req", 32'(bus.coin_req), 32'd0);
      sale(3'd1, 7'd10);
      chk("t4d_error_clr", 32'(bus.error), 32'd0);
      chk("t4d_tkt_req",   32'(bus.tkt_req), 32'd1);
      step();
      chk("t4d_sel",       32'(bus.coin_sel), 32'd2);
      step();
      chk("t4d_done",      32'(bus.done), 32'd1);
      step();

      // Reset during COIN with $40 owed; a mid-sale start is ignored
      bus.coin_ack = 1'b0;
      sale(3'd1, 7'd40);
      step();
      chk("t5_coin_req", 32'(bus.coin_req), 32'd1);
      chk("t5_change",   32'(bus.change_left), 32'd40);
      bus.start        = 1'b1;
      bus.ticket_count = 3'd3;
      bus.change_amt   = 7'd15;
      step();
      bus.start        = 1'b0;
      chk("t5_ign_change",   32'(bus.change_left), 32'd40);
      chk("t5_ign_issued",   32'(bus.tickets_issued), 32'd1);
      chk("t5_ign_coin_req", 32'(bus.coin_req), 32'd1);
      chk("t5_ign_tkt_req",  32'(bus.tkt_req), 32'd0);
      reset = 1'b0;
      step();
      chk("t5_rst_coin_req", 32'(bus.coin_req), 32'd0);
      chk("t5_rst_tkt_req",  32'(bus.tkt_req), 32'd0);
      chk("t5_rst_busy",     32'(bus.busy), 32'd0);
      chk("t5_rst_done",     32'(bus.done), 32'd0);
      chk("t5_rst_error",    32'(bus.error), 32'd0);
      chk("t5_rst_issued",   32'(bus.tickets_issued), 32'd0);
      chk("t5_rst_change",   32'(bus.change_left), 32'd0);
      chk("t5_rst_sel",      32'(bus.coin_sel), 32'd0);
      reset = 1'b1;
      step();
      chk("t5_idle_busy",    32'(bus.busy), 32'd0);

      // Hopper stuck: with no watchdog, coin_req stays high
      sale(3'd1, 7'd5);
      step();
      high_cnt = 0;
      done_cnt = 0;
      for (int i = 0; i < 1000; i++) begin
         step();
         if (bus.coin_req === 1'b1) high_cnt++;
         if (bus.done === 1'b1) done_cnt++;
      end
      chk("t6_coin_req_held", 32'(high_cnt), 32'd1000);
      chk("t6_no_done",       32'(done_cnt), 32'd0);
      chk("t6_change",        32'(bus.change_left), 32'd5);
      chk("t6_error",         32'(bus.error), 32'd0);
      reset = 1'b0;
      step();
      reset = 1'b1;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
